// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA self-checking program sequencer.
// Instruction field layout, report bytes and FSM state encodings.
package esfa_pkg;

  localparam int INSTR_W    = 56;
  localparam int WW_BIT     = 0;
  localparam int NIDX_LSB   = 8;
  localparam int NVAL_LSB   = 16;
  localparam int META_LSB   = 24;
  localparam int ISMETA_BIT = 32;
  localparam int SEL_LSB    = 40;
  localparam int ASSERT_BIT = 48;

  localparam logic [7:0] PASS_BYTE = 8'hAA;
  localparam logic [7:0] FAIL_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } seq_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_FREE,
    T_RISE,
    T_FALL
  } tx_state_e;

  typedef struct packed {
    logic [7:0] new_index;
    logic [7:0] new_value;
    logic [7:0] metadata;
    logic       is_metadata;
    logic [7:0] selector;
    logic       asrt;
  } instr_t;

endpackage

// File: rtl/esfa_report_tx.sv
// Sends a one- or two-byte report over the UART handshake.
// ack pulses once the final byte has left the transmitter.
module esfa_report_tx
  import esfa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] nbytes,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       transmit,
  output logic       ack
);

  tx_state_e  state;
  logic       second_pending;
  logic [7:0] next_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= T_IDLE;
      tx_byte        <= 8'h00;
      transmit       <= 1'b0;
      ack            <= 1'b0;
      second_pending <= 1'b0;
      next_byte      <= 8'h00;
    end else begin
      transmit <= 1'b0;
      ack      <= 1'b0;
      unique case (state)
        T_IDLE: begin
          if (req) begin
            tx_byte        <= b0;
            next_byte      <= b1;
            second_pending <= (nbytes == 2'd2);
            state          <= T_FREE;
          end
        end
        T_FREE: begin
          if (!is_transmitting) begin
            transmit <= 1'b1;
            state    <= T_RISE;
          end
        end
        T_RISE: begin
          if (is_transmitting) begin
            state <= T_FALL;
          end
        end
        T_FALL: begin
          if (!is_transmitting) begin
            if (second_pending) begin
              tx_byte        <= next_byte;
              second_pending <= 1'b0;
              state          <= T_FREE;
            end else begin
              ack   <= 1'b1;
              state <= T_IDLE;
            end
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/esfa_test_sequencer.sv
// Walks the instruction ROM, drives ESFADesign and checks asserted
// results, then reports pass/fail bytes over the UART.
module esfa_test_sequencer
  import esfa_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int RESULT_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_instr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [55:0]       rom_data,
  output logic              esfa_will_write,
  output logic [7:0]        esfa_new_index,
  output logic [7:0]        esfa_new_value,
  output logic [7:0]        esfa_metadata,
  output logic [7:0]        esfa_selector,
  output logic              esfa_is_metadata,
  input  logic              res_bool,
  input  logic [7:0]        res_value,
  output logic [7:0]        tx_byte,
  output logic              transmit,
  input  logic              is_transmitting,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int CNT_W =
    (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LATENCY - 1);
  localparam logic [ADDR_W:0] PC_ONE = 1;
  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  seq_state_e       state;
  logic [ADDR_W:0]  pc;
  logic [ADDR_W:0]  pc_inc;
  logic [ADDR_W:0]  n_instr;
  logic [ADDR_W:0]  n_sat;
  logic [CNT_W-1:0] wait_cnt;
  instr_t           ir;
  logic             res_pass;
  logic [7:0]       fail_idx;
  logic             rpt_req;
  logic [1:0]       rpt_nbytes;
  logic [7:0]       rpt_b0;
  logic             rpt_ack;
  logic             mismatch;
  logic             last;
  logic             unused_rom;

  assign unused_rom = ^{rom_data[7:1], rom_data[39:33],
                        rom_data[55:49]};

  assign esfa_new_index   = ir.new_index;
  assign esfa_new_value   = ir.new_value;
  assign esfa_metadata    = ir.metadata;
  assign esfa_selector    = ir.selector;
  assign esfa_is_metadata = ir.is_metadata;

  assign pc_inc = pc + PC_ONE;
  assign last   = (pc_inc == n_instr);
  assign n_sat  = (num_instr > MAX_N) ? MAX_N : num_instr;
  assign rpt_b0 = res_pass ? PASS_BYTE : FAIL_BYTE;

  assign mismatch = ir.asrt &&
    ((res_bool != ir.is_metadata) || (res_value != ir.metadata));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= '0;
      n_instr         <= '0;
      wait_cnt        <= '0;
      ir              <= '0;
      rom_addr        <= '0;
      esfa_will_write <= 1'b0;
      res_pass        <= 1'b0;
      fail_idx        <= 8'h00;
      rpt_req         <= 1'b0;
      rpt_nbytes      <= 2'd1;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      esfa_will_write <= 1'b0;
      rpt_req         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            pc       <= '0;
            rom_addr <= '0;
            n_instr  <= n_sat;
            if (num_instr == '0) begin
              res_pass   <= 1'b1;
              rpt_nbytes <= 2'd1;
              rpt_req    <= 1'b1;
              state      <= S_REPORT;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          ir.new_index    <= rom_data[NIDX_LSB +: 8];
          ir.new_value    <= rom_data[NVAL_LSB +: 8];
          ir.metadata     <= rom_data[META_LSB +: 8];
          ir.is_metadata  <= rom_data[ISMETA_BIT];
          ir.selector     <= rom_data[SEL_LSB +: 8];
          ir.asrt         <= rom_data[ASSERT_BIT];
          esfa_will_write <= rom_data[WW_BIT];
          state           <= S_ISSUE;
        end
        S_ISSUE: begin
          wait_cnt <= CNT_LOAD;
          state    <= (RESULT_LATENCY > 1) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          // WAIT occupies RESULT_LATENCY-1 cycles; CHECK is the last one
          if (wait_cnt <= CNT_ONE) begin
            wait_cnt <= '0;
            state    <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            res_pass   <= 1'b0;
            fail_idx   <= 8'(pc);
            rpt_nbytes <= 2'd2;
            rpt_req    <= 1'b1;
            state      <= S_REPORT;
          end else if (last) begin
            res_pass   <= 1'b1;
            rpt_nbytes <= 2'd1;
            rpt_req    <= 1'b1;
            state      <= S_REPORT;
          end else begin
            pc       <= pc_inc;
            rom_addr <= pc_inc[ADDR_W-1:0];
            state    <= S_FETCH;
          end
        end
        S_REPORT: begin
          if (rpt_ack) begin
            done  <= 1'b1;
            pass  <= res_pass;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  esfa_report_tx u_report_tx (
    .clk             (clk),
    .rst             (rst),
    .req             (rpt_req),
    .nbytes          (rpt_nbytes),
    .b0              (rpt_b0),
    .b1              (fail_idx),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .ack             (rpt_ack)
  );

endmodule

// File: tb/tb_esfa_test_sequencer.sv
// Directed bench for esfa_test_sequencer with ROM, ESFA and UART models.
// Expected bytes, offsets and flags are hand-computed per scenario.
module tb_esfa_test_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  num_instr = '0;
  logic [7:0]  rom_addr;
  logic [55:0] rom_data;
  logic        esfa_will_write;
  logic [7:0]  esfa_new_index;
  logic [7:0]  esfa_new_value;
  logic [7:0]  esfa_metadata;
  logic [7:0]  esfa_selector;
  logic        esfa_is_metadata;
  logic        res_bool;
  logic [7:0]  res_value;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        is_transmitting;
  logic        busy;
  logic        done;
  logic        pass;

  always #5 clk = ~clk;

  esfa_test_sequencer #(
    .ADDR_W         (8),
    .RESULT_LATENCY (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_instr        (num_instr),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .esfa_will_write  (esfa_will_write),
    .esfa_new_index   (esfa_new_index),
    .esfa_new_value   (esfa_new_value),
    .esfa_metadata    (esfa_metadata),
    .esfa_selector    (esfa_selector),
    .esfa_is_metadata (esfa_is_metadata),
    .res_bool         (res_bool),
    .res_value        (res_value),
    .tx_byte          (tx_byte),
    .transmit         (transmit),
    .is_transmitting  (is_transmitting),
    .busy             (busy),
    .done             (done),
    .pass             (pass)
  );

  // instruction ROM, one-cycle read latency
  logic [55:0] rom [256];
  logic [55:0] rom_q = '0;
  always @(posedge clk) rom_q <= rom[rom_addr];
  assign rom_data = rom_q;

  // behavioural ESFA: register file, result is the selected entry
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (esfa_will_write) begin
      mem[esfa_new_index] <= esfa_new_value;
    end
  end
  assign res_value = mem[esfa_selector];
  assign res_bool  = (mem[esfa_selector] != 8'h00);

  // UART: busy for 4 cycles per byte, plus an external hold
  logic       uart_busy = 1'b0;
  int         uart_cnt = 0;
  logic [7:0] uart_cur = 8'h00;
  int         viol = 0;
  logic       hold_busy = 1'b0;
  logic [7:0] tx_q [$];
  assign is_transmitting = uart_busy | hold_busy;
  always @(posedge clk) begin
    if (transmit) begin
      if (is_transmitting) viol <= viol + 1;
      tx_q.push_back(tx_byte);
      uart_cur  <= tx_byte;
      uart_busy <= 1'b1;
      uart_cnt  <= 4;
    end else if (uart_busy) begin
      if (tx_byte != uart_cur) viol <= viol + 1;
      if (uart_cnt == 1) uart_busy <= 1'b0;
      uart_cnt <= uart_cnt - 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] mk(
    input logic ww, input logic [7:0] idx, input logic [7:0] val,
    input logic [7:0] meta, input logic im, input logic [7:0] sel,
    input logic as
  );
    logic [55:0] w;
    w = '1;
    w[0] = ww;
    w[15:8] = idx;
    w[23:16] = val;
    w[31:24] = meta;
    w[32] = im;
    w[47:40] = sel;
    w[48] = as;
    return w;
  endfunction

  int   ww_offs [$];
  logic [7:0] max_addr;
  logic [7:0] first_addr;
  int   tx_base;
  int   viol_base;

  task automatic run(input logic [8:0] n, input int limit);
    ww_offs.delete();
    max_addr = 8'h00;
    tx_base = tx_q.size();
    viol_base = viol;
    @(negedge clk);
    num_instr = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_addr = rom_addr;
    for (int k = 1; k <= limit; k++) begin
      if (esfa_will_write) ww_offs.push_back(k);
      if (rom_addr > max_addr) max_addr = rom_addr;
      if (done) break;
      @(negedge clk);
    end
    check("done_in_time", 64'(done), 64'(1));
  endtask

  task automatic check_bytes(input string tag, input int nexp,
                             input logic [7:0] e0, input logic [7:0] e1);
    int got_n;
    got_n = tx_q.size() - tx_base;
    check({tag, "_nbytes"}, 64'(got_n), 64'(nexp));
    if (got_n >= 1) check({tag, "_b0"}, 64'(tx_q[tx_base]), 64'(e0));
    if (nexp == 2 && got_n >= 2)
      check({tag, "_b1"}, 64'(tx_q[tx_base+1]), 64'(e1));
    check({tag, "_uart_viol"}, 64'(viol - viol_base), 64'(0));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rom_addr, esfa_will_write, esfa_new_index,
                esfa_new_value, esfa_metadata, esfa_selector,
                esfa_is_metadata, tx_byte, transmit, busy, done, pass});
  endfunction

  initial begin
    int c;
    int pulses;
    int bad;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // empty program
    run(9'd0, 200);
    check("empty_max_addr", 64'(max_addr), 64'(0));
    check("empty_pass", 64'({done, pass, busy}), 64'(3'b110));
    check_bytes("empty", 1, 8'hAA, 8'h00);

    // four unasserted writes: ISSUE cycles 3,7,11,15
    for (int i = 0; i < 4; i++)
      rom[i] = mk(1'b1, 8'(i), 8'(8'h10 + i), 8'h00, 1'b0, 8'h00, 1'b0);
    run(9'd4, 200);
    check("ww_count", 64'(ww_offs.size()), 64'(4));
    for (int i = 0; i < 4 && i < ww_offs.size(); i++)
      check("ww_offset", 64'(ww_offs[i]), 64'(3 + 4 * i));
    check("four_pass", 64'(pass), 64'(1));
    check_bytes("four", 1, 8'hAA, 8'h00);

    // three matching asserts
    rom[0] = mk(1'b1, 8'h05, 8'h33, 8'h33, 1'b1, 8'h05, 1'b1);
    rom[1] = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h09, 1'b1);
    rom[2] = mk(1'b1, 8'h09, 8'h5A, 8'h5A, 1'b1, 8'h09, 1'b1);
    run(9'd3, 200);
    check("match_pass", 64'({done, pass}), 64'(2'b11));
    check_bytes("match", 1, 8'hAA, 8'h00);

    // instruction 2 expects 0x5A, model holds 0x5B
    rom[0] = mk(1'b1, 8'h07, 8'h5B, 8'h5B, 1'b1, 8'h07, 1'b1);
    rom[1] = mk(1'b1, 8'h08, 8'h01, 8'h01, 1'b1, 8'h08, 1'b1);
    rom[2] = mk(1'b0, 8'h00, 8'h00, 8'h5A, 1'b1, 8'h07, 1'b1);
    rom[3] = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run(9'd4, 200);
    check("fail_pass", 64'({done, pass}), 64'(2'b10));
    check("fail_pc", 64'(rom_addr), 64'(2));
    check("fail_max_addr", 64'(max_addr), 64'(2));
    check_bytes("fail", 2, 8'hEE, 8'h02);

    // failure on the last instruction beats the pass result
    run(9'd3, 200);
    check("lastfail_pass", 64'({done, pass}), 64'(2'b10));
    check_bytes("lastfail", 2, 8'hEE, 8'h02);

    // UART held busy for 1000 cycles
    hold_busy = 1'b1;
    tx_base = tx_q.size();
    viol_base = viol;
    @(negedge clk);
    num_instr = 9'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    pulses = 0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (transmit) pulses++;
      if (tx_byte != 8'hAA) bad++;
      @(negedge clk);
    end
    check("hold_no_pulse", 64'(pulses), 64'(0));
    check("hold_tx_stable", 64'(bad), 64'(0));
    check("hold_busy", 64'({busy, done}), 64'(2'b10));
    hold_busy = 1'b0;
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    check("hold_done", 64'({done, pass}), 64'(2'b11));
    check_bytes("hold", 1, 8'hAA, 8'h00);

    // 0x1FF saturates to 256 instructions, no wrap
    for (int i = 0; i < 256; i++)
      rom[i] = mk(1'b1, 8'(i), 8'(i), 8'h00, 1'b0, 8'h00, 1'b0);
    run(9'h1FF, 2000);
    check("sat_count", 64'(ww_offs.size()), 64'(256));
    check("sat_max_addr", 64'(max_addr), 64'(255));
    check("sat_pass", 64'(pass), 64'(1));
    check_bytes("sat", 1, 8'hAA, 8'h00);

    // reset during instruction 5, then rerun
    @(negedge clk);
    num_instr = 9'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    for (int k = 0; k < 200 && c < 6; k++) begin
      if (esfa_will_write) c++;
      if (c < 6) @(negedge clk);
    end
    check("rst_reach_instr5", 64'(c), 64'(6));
    @(negedge clk);
    check("rst_pre_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", all_outs(), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run(9'd8, 200);
    check("rerun_first_addr", 64'(first_addr), 64'(0));
    check("rerun_count", 64'(ww_offs.size()), 64'(8));
    check("rerun_pass", 64'({done, pass}), 64'(2'b11));
    check_bytes("rerun", 1, 8'hAA, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
